// File: rtl/reset_seq_pkg.sv
// reset_seq_pkg
//   Shared types and constants for the reset sequencer slice.
//   rst_state_t   : sequencer FSM states (encoding is visible on the debug port).
//   RST_COUNT_MAX : saturation value of the button-initiated reset counter.
//   cnt_width()   : counter width for a cycle count, never less than 1 bit.
package reset_seq_pkg;

    typedef enum logic [1:0] {
        ASSERTED = 2'd0,
        HOLD     = 2'd1,
        RUN      = 2'd2
    } rst_state_t;

    localparam logic [7:0] RST_COUNT_MAX = 8'd255;

    function automatic int unsigned cnt_width(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/reset_sequencer_sync_debounce.sv
// sync_debounce
//   Brings the raw pushbutton into the CLK domain and debounces it.
//   Ports:
//     CLK        in  fast FPGA clock
//     RESET      in  asynchronous active-high reset
//     btn        in  raw, asynchronous, bouncing pushbutton
//     btn_stable out debounced level, 1 = pressed
module sync_debounce
    import reset_seq_pkg::*;
#(
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 50000,
    parameter bit          BTN_ACTIVE_LOW  = 1'b1
) (
    input  logic CLK,
    input  logic RESET,
    input  logic btn,
    output logic btn_stable
);

    localparam int unsigned    DW       = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [DW-1:0]  DEB_LAST = DW'(DEBOUNCE_CYCLES - 1);
    // Raw level the button shows when it is not pressed.
    localparam logic           IDLE_LVL = BTN_ACTIVE_LOW;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   btn_sync;
    logic [DW-1:0]          deb_cnt;
    logic                   stable_q;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            sync_q <= {SYNC_STAGES{IDLE_LVL}};
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], btn};
        end
    end

    // Normalise polarity so that 1 always means pressed.
    assign btn_sync = sync_q[SYNC_STAGES-1] ^ BTN_ACTIVE_LOW;

    // The counter only runs while the synchronized level disagrees with the
    // accepted level; any agreeing cycle restarts the qualification window.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            deb_cnt  <= '0;
            stable_q <= 1'b0;
        end else if (btn_sync == stable_q) begin
            deb_cnt  <= '0;
        end else if (deb_cnt == DEB_LAST) begin
            deb_cnt  <= '0;
            stable_q <= ~stable_q;
        end else begin
            deb_cnt  <= deb_cnt + DW'(1);
        end
    end

    assign btn_stable = stable_q;

endmodule

// File: rtl/reset_sequencer.sv
// reset_sequencer
//   Produces a clean registered active-low reset for the SoC from a raw
//   pushbutton: synchronize, debounce, then hold reset for a fixed time
//   after the button is released.
//   Ports:
//     CLK         in  fast FPGA clock
//     RESET       in  asynchronous active-high global reset
//     btn         in  raw, asynchronous, bouncing pushbutton
//     resetn      out registered active-low SoC reset (0 = in reset)
//     rst_state   out current FSM state encoding (debug/LED)
//     btn_stable  out debounced button level, 1 = pressed
//     reset_count out saturating count of button-initiated resets
module reset_sequencer
    import reset_seq_pkg::*;
#(
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 50000,
    parameter int unsigned HOLD_CYCLES     = 1024,
    parameter bit          BTN_ACTIVE_LOW  = 1'b1
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       btn,
    output logic       resetn,
    output logic [1:0] rst_state,
    output logic       btn_stable,
    output logic [7:0] reset_count
);

    localparam int unsigned   HW        = cnt_width(HOLD_CYCLES);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);

    logic       pressed;
    rst_state_t state_q,  state_d;
    logic [HW-1:0] hold_q, hold_d;
    logic       resetn_q, resetn_d;
    logic [7:0] count_q,  count_d;

    sync_debounce #(
        .SYNC_STAGES     (SYNC_STAGES),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .BTN_ACTIVE_LOW  (BTN_ACTIVE_LOW)
    ) u_sync_debounce (
        .CLK        (CLK),
        .RESET      (RESET),
        .btn        (btn),
        .btn_stable (pressed)
    );

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q  <= ASSERTED;
            hold_q   <= '0;
            resetn_q <= 1'b0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            hold_q   <= hold_d;
            resetn_q <= resetn_d;
            count_q  <= count_d;
        end
    end

    always_comb begin
        state_d = state_q;
        hold_d  = '0;
        count_d = count_q;
        case (state_q)
            ASSERTED: begin
                if (!pressed) state_d = HOLD;
            end
            HOLD: begin
                // A new press wins over hold completion.
                if (pressed) begin
                    state_d = ASSERTED;
                end else if (hold_q == HOLD_LAST) begin
                    state_d = RUN;
                end else begin
                    hold_d = hold_q + HW'(1);
                end
            end
            RUN: begin
                if (pressed) begin
                    state_d = ASSERTED;
                    if (count_q != RST_COUNT_MAX) count_d = count_q + 8'd1;
                end
            end
            default: state_d = ASSERTED;
        endcase
        // resetn is registered from the next state so it moves on the same
        // edge the FSM enters or leaves RUN, with no decode glitches.
        resetn_d = (state_d == RUN);
    end

    assign resetn      = resetn_q;
    assign rst_state   = state_q;
    assign btn_stable  = pressed;
    assign reset_count = count_q;

endmodule
